instruction_loader: RTL and testbench

Debug-side controller that owns the instruction-memory write port during program download. It consumes a byte stream from the host link (UART receive path) and parses a length-prefixed frame. It packs bytes big-endian into 32-bit instructions and issues one write per word at consecutive word addresses. The CPU is held stalled from the start of the frame until the frame completes successfully.

---
 rtl/instruction_loader.sv | 133 +++++++++++++
 tb/tb_instruction_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// instruction_loader: length-prefixed program download into imem; define LOADER_CHECKSUM_EN for a trailing XOR checksum byte
module instruction_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        cpu_hold,
  output logic        imem_we,
  output logic [31:0] imem_pc,
  output logic [31:0] imem_instruction,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);
  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    DATA,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE
  } state_t;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t end_st = CSUM;
`else
  localparam state_t end_st = DONE;
`endif
  state_t state, state_n;
  logic [15:0] count, count_n, wl_n, wl_inc;
  logic [1:0] idx, idx_n;
  logic [31:0] tcnt, tcnt_n, pc_n, word_n, n_full;
  logic hold_n, err_n, accept, timed;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum, csum_n;
  always_comb csum_n = !accept ? csum : state == IDLE ? byte_data : csum ^ byte_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) csum <= 8'h00;
    else csum <= csum_n;
`endif
  always_comb begin
    accept = byte_valid & byte_ready;
    timed = byte_ready & busy;
    n_full = {16'h0000, count[15:8], byte_data};
    wl_inc = words_loaded + 16'd1;
    state_n = state;
    count_n = count;
    idx_n = idx;
    pc_n = imem_pc;
    word_n = imem_instruction;
    wl_n = words_loaded;
    hold_n = cpu_hold;
    err_n = error;
    tcnt_n = accept ? 32'd0 : timed ? tcnt + 32'd1 : tcnt;
    case (state)
      IDLE: if (accept) begin
        state_n = HDR_LO;
        count_n = {byte_data, 8'h00};
        hold_n = 1'b1;
        err_n = 1'b0;
        wl_n = 16'd0;
        pc_n = BASE_ADDR;
      end
      HDR_LO: if (accept) begin
        count_n = n_full[15:0];
        idx_n = 2'd0;
        err_n = n_full > MAX_WORDS;
        state_n = n_full > MAX_WORDS ? IDLE : n_full == 32'd0 ? end_st : DATA;
      end
      DATA: if (accept) begin
        word_n = {imem_instruction[23:0], byte_data};
        idx_n = idx + 2'd1;
        state_n = idx == 2'd3 ? WRITE : DATA;
      end
      WRITE: begin
        pc_n = imem_pc + 32'd4;
        wl_n = wl_inc;
        state_n = wl_inc < count ? DATA : end_st;
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: if (accept) begin
        state_n = byte_data == csum ? DONE : IDLE;
        err_n = byte_data != csum;
      end
`endif
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (TIMEOUT_CYCLES != 0 && timed && !accept && tcnt == TIMEOUT_CYCLES - 1) begin
      state_n = IDLE;
      err_n = 1'b1;
    end
    if (state_n == DONE) hold_n = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= 16'd0;
      idx <= 2'd0;
      tcnt <= 32'd0;
      byte_ready <= 1'b0;
      cpu_hold <= 1'b0;
      imem_we <= 1'b0;
      imem_pc <= BASE_ADDR;
      imem_instruction <= 32'd0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      words_loaded <= 16'd0;
    end else begin
      state <= state_n;
      count <= count_n;
      idx <= idx_n;
      tcnt <= tcnt_n;
      byte_ready <= state_n != WRITE && state_n != DONE;
      cpu_hold <= hold_n;
      imem_we <= state_n == WRITE;
      imem_pc <= pc_n;
      imem_instruction <= word_n;
      busy <= state_n != IDLE;
      done <= state_n == DONE;
      error <= err_n;
      words_loaded <= wl_n;
    end
  end
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: directed self-checking bench for instruction_loader
module tb_instruction_loader;
  logic clk = 1'b0, rst_n = 1'b0, byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic byte_ready, cpu_hold, imem_we, busy, done, error;
  logic [31:0] imem_pc, imem_instruction;
  logic [15:0] words_loaded;
  int n_checks = 0, n_fail = 0, nwr = 0, ndone = 0, wr_base = 0, done_base = 0;
  logic [31:0] wr_pc [0:31];
  logic [31:0] wr_data [0:31];
  logic [31:0] prog [0:4];
  logic [7:0] tb_x = 8'h00;

  instruction_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(1024), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .cpu_hold(cpu_hold), .imem_we(imem_we), .imem_pc(imem_pc),
    .imem_instruction(imem_instruction), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n) begin
    if (imem_we && nwr < 32) begin
      wr_pc[nwr] = imem_pc;
      wr_data[nwr] = imem_instruction;
      nwr++;
    end
    if (done) ndone++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed no end, expected end");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int g = 0;
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data = b;
    tb_x ^= b;
    while (!byte_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("byte_accept", {31'd0, g < 20}, 32'd1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(w[8*i +: 8]);
  endtask

  task automatic start_frame();
    tb_x = 8'h00;
    wr_base = nwr;
    done_base = ndone;
  endtask

  task automatic end_frame(input bit had_data);
`ifdef LOADER_CHECKSUM_EN
    send(tb_x);
`else
    if (had_data) tick(1);
`endif
  endtask

  initial begin
    prog[0] = 32'h8C09_0000;
    prog[1] = 32'h2008_0004;
    prog[2] = 32'h8D02_0000;
    prog[3] = 32'hAC49_0000;
    prog[4] = 32'h0800_0000;
    tick(2);
    check("rst_byte_ready", byte_ready, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_imem_we", imem_we, 0);
    check("rst_imem_pc", imem_pc, 32'h0);
    check("rst_instr", imem_instruction, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_words", words_loaded, 0);
    @(negedge clk) rst_n = 1'b1;
    tick(1);
    check("idle_ready", byte_ready, 1);
    check("idle_busy", busy, 0);

    start_frame();
    send(8'h00);
    check("f1_hold_on", cpu_hold, 1);
    check("f1_busy", busy, 1);
    send(8'h05);
    for (int i = 0; i < 5; i++) send_word(prog[i]);
    check("f1_last_we", imem_we, 1);
    check("f1_last_pc", imem_pc, 32'h10);
    check("f1_last_instr", imem_instruction, 32'h0800_0000);
    end_frame(1);
    check("f1_done", done, 1);
    check("f1_hold_off", cpu_hold, 0);
    check("f1_words", words_loaded, 5);
    check("f1_error", error, 0);
    tick(1);
    check("f1_done_pulse", done, 0);
    check("f1_idle", busy, 0);
    check("f1_ready", byte_ready, 1);
    check("f1_nwrites", nwr - wr_base, 5);
    for (int i = 0; i < 5; i++) begin
      check("f1_wr_pc", wr_pc[wr_base + i], 32'(4 * i));
      check("f1_wr_data", wr_data[wr_base + i], prog[i]);
    end
    check("f1_ndone", ndone - done_base, 1);

    start_frame();
    send(8'h00);
    send(8'h00);
    end_frame(0);
    check("f0_done", done, 1);
    check("f0_hold_off", cpu_hold, 0);
    check("f0_words", words_loaded, 0);
    tick(1);
    check("f0_done_pulse", done, 0);
    check("f0_nwrites", nwr - wr_base, 0);

    start_frame();
    send(8'h04);
    send(8'h01);
    check("big_error", error, 1);
    check("big_hold", cpu_hold, 1);
    check("big_busy", busy, 0);
    tick(5);
    check("big_nwrites", nwr - wr_base, 0);
    check("big_ndone", ndone - done_base, 0);
    check("big_sticky", error, 1);
    check("big_hold_kept", cpu_hold, 1);

    start_frame();
    send(8'h00);
    check("rec_err_clr", error, 0);
    check("rec_hold", cpu_hold, 1);
    send(8'h01);
    send_word(32'hDEAD_BEEF);
    check("rec_we", imem_we, 1);
    check("rec_pc", imem_pc, 32'h0);
    check("rec_instr", imem_instruction, 32'hDEAD_BEEF);
    end_frame(1);
    check("rec_done", done, 1);
    check("rec_hold_off", cpu_hold, 0);
    check("rec_we_off", imem_we, 0);
    check("rec_pc_next", imem_pc, 32'h4);
    check("rec_words", words_loaded, 1);
    check("rec_nwrites", nwr - wr_base, 1);
    check("rec_wr_data", wr_data[wr_base], 32'hDEAD_BEEF);
    tick(1);

    start_frame();
    send(8'h00);
    send(8'h01);
    send(8'hAA);
    send(8'hBB);
    tick(15);
    check("to_early", error, 0);
    check("to_busy", busy, 1);
    tick(1);
    check("to_error", error, 1);
    check("to_hold", cpu_hold, 1);
    check("to_idle", busy, 0);
    check("to_nwrites", nwr - wr_base, 0);

    start_frame();
    send(8'h00);
    send(8'h02);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    check("mr_err_clr", error, 0);
    check("mr_hold", cpu_hold, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mr_ready", byte_ready, 0);
    check("mr_hold_off", cpu_hold, 0);
    check("mr_busy", busy, 0);
    check("mr_we", imem_we, 0);
    check("mr_pc", imem_pc, 32'h0);
    check("mr_instr", imem_instruction, 32'h0);
    check("mr_words", words_loaded, 0);
    tick(2);
    @(negedge clk) rst_n = 1'b1;
    tick(3);
    check("mr_nwrites", nwr - wr_base, 0);
    start_frame();
    send(8'h00);
    send(8'h01);
    send_word(32'h1234_5678);
    end_frame(1);
    check("mr2_done", done, 1);
    check("mr2_hold_off", cpu_hold, 0);
    check("mr2_nwrites", nwr - wr_base, 1);
    check("mr2_wr_pc", wr_pc[wr_base], 32'h0);
    check("mr2_wr_data", wr_data[wr_base], 32'h1234_5678);
    tick(1);

`ifdef LOADER_CHECKSUM_EN
    start_frame();
    send(8'h00);
    send(8'h01);
    send_word(32'h1234_5678);
    send(8'h00);
    check("cs_error", error, 1);
    check("cs_no_done", done, 0);
    check("cs_hold", cpu_hold, 1);
    tick(3);
    check("cs_ndone", ndone - done_base, 0);
    check("cs_nwrites", nwr - wr_base, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
